// File: rtl/ucq_multi.sv
// ucq_multi: multi-lane unit-clause queue with dedup and conflict detection.
// FWFT head, all-or-nothing multi-lane push, sticky conflict/overflow flags.
module ucq_multi #(
    parameter int LIT_W = 8,
    parameter int DEPTH = 16,
    parameter int NPUSH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPUSH-1:0]         push_vld,
    input  logic [NPUSH*LIT_W-1:0]   push_lit,
    output logic                     push_rdy,
    input  logic                     pop,
    output logic [LIT_W-1:0]         pop_lit,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     flush,
    output logic                     conflict,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [LIT_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    cnt;
    logic             cflt_q;
    logic             ovf_q;

    logic [LIT_W-1:0] lit [NPUSH];
    logic [AW-1:0]    slot [NPUSH];
    logic [NPUSH-1:0] acc;
    logic [CW-1:0]    n_acc;
    logic             cflt_hit;
    logic             hit;
    logic             cmp;
    logic             dup;
    logic             do_pop;
    logic             push_cyc;

    assign count    = cnt;
    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign push_rdy = (cnt <= CW'(DEPTH - NPUSH));
    assign pop_lit  = empty ? '0 : mem[head];
    assign conflict = cflt_q;
    assign ovf      = ovf_q;
    assign do_pop   = pop & ~empty;
    assign push_cyc = |push_vld;

    // Lanes resolved in index order; accepted lanes pack contiguously at tail.
    always_comb begin
        acc      = '0;
        n_acc    = '0;
        cflt_hit = 1'b0;
        hit      = 1'b0;
        cmp      = 1'b0;
        dup      = 1'b0;
        for (int i = 0; i < NPUSH; i++) begin
            lit[i]  = push_lit[i*LIT_W +: LIT_W];
            slot[i] = '0;
        end
        for (int i = 0; i < NPUSH; i++) begin
            hit = 1'b0;
            cmp = 1'b0;
            dup = 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
                if (vld[e] && mem[e] == lit[i])
                    hit = 1'b1;
                if (vld[e] && mem[e] == (lit[i] ^ LIT_W'(1)))
                    cmp = 1'b1;
            end
            for (int j = 0; j < NPUSH; j++) begin
                if (j < i && acc[j] && lit[j] == lit[i])
                    dup = 1'b1;
                if (j != i && push_vld[j] && lit[j] == (lit[i] ^ LIT_W'(1)))
                    cmp = 1'b1;
            end
            if (push_vld[i] && push_rdy) begin
                if (cmp)
                    cflt_hit = 1'b1;
                if (!hit && !dup) begin
                    acc[i]  = 1'b1;
                    slot[i] = tail + n_acc[AW-1:0];
                    n_acc   = n_acc + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head   <= '0;
            tail   <= '0;
            cnt    <= '0;
            vld    <= '0;
            cflt_q <= 1'b0;
            ovf_q  <= 1'b0;
            for (int e = 0; e < DEPTH; e++)
                mem[e] <= '0;
        end else if (flush) begin
            head   <= '0;
            tail   <= '0;
            cnt    <= '0;
            vld    <= '0;
            cflt_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_pop) begin
                vld[head] <= 1'b0;
                head      <= head + AW'(1);
            end
            for (int i = 0; i < NPUSH; i++) begin
                if (acc[i]) begin
                    mem[slot[i]] <= lit[i];
                    vld[slot[i]] <= 1'b1;
                end
            end
            tail <= tail + n_acc[AW-1:0];
            cnt  <= cnt + n_acc - CW'(do_pop);
            if (cflt_hit)
                cflt_q <= 1'b1;
            if (push_cyc && !push_rdy)
                ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ucq_multi.sv
// tb_ucq_multi: scoreboard bench for ucq_multi (NPUSH=2, DEPTH=16).
// Model queue holds expected literals; pops are checked against its front.
module tb_ucq_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  push_vld = '0;
    logic [15:0] push_lit = '0;
    logic        push_rdy;
    logic        pop = 1'b0;
    logic [7:0]  pop_lit;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic        flush = 1'b0;
    logic        conflict;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq [$];
    bit         mc = 0;
    bit         mo = 0;

    ucq_multi #(.LIT_W(8), .DEPTH(16), .NPUSH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_lit (push_lit),
        .push_rdy (push_rdy),
        .pop      (pop),
        .pop_lit  (pop_lit),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .flush    (flush),
        .conflict (conflict),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == 16));
        chk({tag, ".rdy"}, 32'(push_rdy), 32'((16 - n) >= 2));
        chk({tag, ".lit"}, 32'(pop_lit), (n == 0) ? 32'h0 : 32'(mq[0]));
        chk({tag, ".cflt"}, 32'(conflict), 32'(mc));
        chk({tag, ".ovf"}, 32'(ovf), 32'(mo));
    endtask

    // Drive one cycle, update the model, check state after the edge.
    task automatic cyc(input string tag, input logic [1:0] v,
                       input logic [7:0] l0, input logic [7:0] l1,
                       input logic p, input logic f);
        logic [7:0] l [2];
        logic [7:0] aq [$];
        bit rdy;
        bit found;
        l[0] = l0;
        l[1] = l1;
        push_vld = v;
        push_lit = {l1, l0};
        pop = p;
        flush = f;
        if (f) begin
            mq.delete();
            mc = 0;
            mo = 0;
        end else begin
            rdy = (16 - mq.size()) >= 2;
            if (v != 2'b00 && !rdy)
                mo = 1;
            if (v != 2'b00 && rdy) begin
                for (int i = 0; i < 2; i++) begin
                    if (v[i]) begin
                        found = 0;
                        foreach (mq[e]) begin
                            if (mq[e] == (l[i] ^ 8'h01)) mc = 1;
                            if (mq[e] == l[i]) found = 1;
                        end
                        foreach (aq[e])
                            if (aq[e] == l[i]) found = 1;
                        for (int j = 0; j < 2; j++)
                            if (j != i && v[j] && l[j] == (l[i] ^ 8'h01))
                                mc = 1;
                        if (!found) aq.push_back(l[i]);
                    end
                end
            end
            if (p && mq.size() > 0)
                chk({tag, ".pop"}, 32'(pop_lit), 32'(mq.pop_front()));
            foreach (aq[e]) mq.push_back(aq[e]);
        end
        @(posedge clk);
        #1;
        push_vld = '0;
        pop = 1'b0;
        flush = 1'b0;
        chk_state(tag);
    endtask

    initial begin
        #12;
        chk_state("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_state("rel");

        // basic order
        cyc("b_push", 2'b11, 8'h04, 8'h08, 0, 0);
        cyc("b_pop1", 2'b00, 8'h00, 8'h00, 1, 0);
        cyc("b_pop2", 2'b00, 8'h00, 8'h00, 1, 0);
        cyc("b_pope", 2'b00, 8'h00, 8'h00, 1, 0);

        // dedup
        cyc("d_seed", 2'b01, 8'h04, 8'h00, 0, 0);
        cyc("d_same", 2'b11, 8'h04, 8'h04, 0, 0);
        cyc("d_pair", 2'b11, 8'h0A, 8'h0A, 0, 0);
        cyc("d_vsq",  2'b10, 8'h00, 8'h0A, 1, 0);
        cyc("d_fl",   2'b00, 8'h00, 8'h00, 0, 1);

        // conflict
        cyc("c_seed", 2'b01, 8'h04, 8'h00, 0, 0);
        cyc("c_comp", 2'b01, 8'h05, 8'h00, 0, 0);
        cyc("c_fl1",  2'b00, 8'h00, 8'h00, 0, 1);
        cyc("c_lane", 2'b11, 8'h10, 8'h11, 0, 0);
        cyc("c_fl2",  2'b11, 8'h30, 8'h32, 1, 1);

        // full / overflow
        for (int k = 0; k < 8; k++)
            cyc("f_fill", 2'b11, 8'(8'h20 + 4*k), 8'(8'h22 + 4*k), 0, 0);
        cyc("f_ovf",  2'b11, 8'h60, 8'h62, 0, 0);
        cyc("f_pp",   2'b11, 8'h70, 8'h72, 1, 0);
        cyc("f_pop",  2'b00, 8'h00, 8'h00, 1, 0);
        cyc("f_re",   2'b01, 8'h21, 8'h00, 0, 0);
        cyc("f_fl",   2'b00, 8'h00, 8'h00, 0, 1);

        // wrap-around stream
        for (int k = 0; k < 64; k++) begin
            cyc("w_str", 2'b01, 8'((k + 1) * 2), 8'h00, k >= 3, 0);
            chk("w_max", 32'(count <= 5'd4), 32'h1);
        end
        for (int k = 0; k < 8 && mq.size() > 0; k++)
            cyc("w_drn", 2'b00, 8'h00, 8'h00, 1, 0);

        // async reset mid-cycle
        cyc("r_p1", 2'b11, 8'h40, 8'h42, 0, 0);
        cyc("r_p2", 2'b11, 8'h44, 8'h46, 0, 0);
        cyc("r_p3", 2'b01, 8'h48, 8'h00, 0, 0);
        chk("r_cnt5", 32'(count), 32'd5);
        #2;
        rst = 1'b0;
        #1;
        mq.delete();
        mc = 0;
        mo = 0;
        chk_state("r_async");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_state("r_rel");
        cyc("r_push", 2'b01, 8'h06, 8'h00, 0, 0);
        cyc("r_pop",  2'b00, 8'h00, 8'h00, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ucq_multi.md
# ucq_multi

Parametrised multi-lane unit-clause queue for the SAT accelerator. It sits between the unit-clause analysers and the propagation engine. It accepts up to NPUSH implied literals per cycle, drops duplicates, and raises a sticky conflict flag when a literal and its complement are both queued. Literals are delivered in FIFO order, one per pop, from a first-word-fall-through head.

## Interface
- LIT_W, 8, literal width; bit 0 = polarity (1 = negated), bits [LIT_W-1:1] = variable index
- DEPTH, 16, queue entries; power of two, >= NPUSH
- NPUSH, 2, push lanes per cycle, 1..4

- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low; clears all state immediately on assertion
- push_vld  input  NPUSH  per-lane push valid
- push_lit  input  NPUSH*LIT_W  per-lane literal, lane i at [i*LIT_W +: LIT_W]
- push_rdy  output  1  high when free slots (DEPTH-count) >= NPUSH
- pop  input  1  consume head literal
- pop_lit  output  LIT_W  head literal; 0 when empty
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- count  output  $clog2(DEPTH)+1  occupied entries
- flush  input  1  synchronous clear of contents and flags
- conflict  output  1  sticky: complementary literals seen
- ovf  output  1  sticky: push_vld asserted while push_rdy low

## Operation
- Storage: DEPTH x LIT_W entry array plus a per-entry valid bit. head/tail are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- A push cycle is any cycle with |push_vld. Acceptance is all-or-nothing:
  - push_rdy=1: every valid lane is evaluated.
  - push_rdy=0: all lanes are ignored and ovf sets.
- Lanes are evaluated in ascending index order. Lane i is dropped (not stored, no count change) if its literal equals:
  - any valid entry at cycle start (including the entry being popped this cycle), or
  - any accepted lane j<i.
- Surviving lanes take consecutive slots from tail, in lane order.
- Conflict sets when a surviving or dropped lane literal equals, with bit 0 inverted, either a valid entry at cycle start or another valid lane in the same cycle. Complementary literals are still stored.
- Pop with empty=1 is ignored. Pop advances head and clears that entry's valid bit.
- count_next = count + accepted_lanes - (pop & ~empty).
- flush has priority over push and pop in the same cycle. Next cycle: count=0, head=tail=0, all valid bits cleared, conflict=0, ovf=0; any push or pop in the flush cycle is discarded.
- Reset values: count=0, empty=1, full=0, push_rdy=1, pop_lit=0, conflict=0, ovf=0, head=tail=0, all entries invalid.
- Reset mid-operation discards everything; outputs take reset values asynchronously.

## Timing
- Push-to-visible latency is 1 cycle. A literal accepted at edge N appears on pop_lit after edge N if the queue was empty.
- pop_lit, empty, full, count and push_rdy are registered-state-derived; none depend combinationally on push or pop inputs.
- Pop at edge N: pop_lit shows the next entry after edge N.
- Simultaneous push and pop on a full queue: push_rdy is already 0, so the push is rejected and ovf sets; the pop proceeds.
- conflict and ovf update at the edge following the offending cycle. They stay high until flush or reset.

## Test plan
- Basic order (NPUSH=2, DEPTH=16):
  - Stimulus: after reset, push 0x04 (lane 0) and 0x08 (lane 1) in one cycle.
  - Response: next cycle count=2, pop_lit=0x04. Pop gives pop_lit=0x08, then pop gives empty=1, pop_lit=0.
- Dedup:
  - Stimulus: queue holds 0x04; push lanes 0x04/0x04, then 0x0A/0x0A.
  - Response: first cycle count unchanged; second cycle count+1 with only one 0x0A stored; conflict stays 0.
- Conflict:
  - Stimulus: queue holds 0x04; push 0x05. Then, on an empty queue, push lanes 0x10/0x11 together.
  - Response: conflict=1 next cycle and count increments. Assert flush: count=0, conflict=0, empty=1.
- Full/overflow:
  - Stimulus: push 7 cycles of distinct pairs (count=14); push one more pair; then push again.
  - Response: after the 8th pair count=16, full=1, push_rdy=0. The extra push sets ovf=1 with count unchanged.
  - Stimulus: pop twice.
  - Response: push_rdy=1.
- Wrap-around:
  - Stimulus: stream 64 distinct literals, pushing one lane per cycle while popping every cycle after the first 3.
  - Response: pop order matches push order across multiple pointer wraps; count never exceeds 4.
- Async reset:
  - Stimulus: with count=5, drive rst low mid-cycle.
  - Response: empty=1, count=0, pop_lit=0 before the next clock edge. After release, a push of 0x06 is popped as 0x06.
